// File: rtl/hart_meter.sv
// Heartbeat front end: synchronizes and debounces the sensor pulse, counts beats per window, flags flatline.
// Optional HART_AVG_EN: report the rounded mean of the current and previous window counts.
module hart_meter #(
  parameter int WINDOW  = 1500,
  parameter int LOCKOUT = 20,
  parameter int NOBEAT  = 300
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       beat,
  output logic [5:0] hart,
  output logic       hart_valid,
  output logic       flatline
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int LK_W  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int NB_W  = $clog2(NOBEAT + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [LK_W-1:0]  LK_LOAD  = LK_W'(LOCKOUT - 1);
  localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(NOBEAT);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    LOCK     = 2'd2
  } state_t;

  function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic inc);
    return (inc && v != 6'd63) ? v + 6'd1 : v;
  endfunction

`ifdef HART_AVG_EN
  function automatic logic [5:0] round_avg(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b} + 7'd1;
    return s[6:1];
  endfunction
`endif

  logic             beat_p0;
  logic             beat_s;
  logic [1:0]       primed;
  state_t           state;
  logic [LK_W-1:0]  lock_cnt;
  logic             acc;
  logic [WIN_W-1:0] win_cnt;
  logic             wend;
  logic [5:0]       beat_cnt;
  logic [5:0]       cur_cnt;
  logic [NB_W-1:0]  fl_cnt;

  // Stage p0/p1: two-flop synchronizer; primed marks when beat_s holds a real sample
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      beat_p0 <= 1'b0;
      beat_s  <= 1'b0;
      primed  <= 2'b00;
    end else begin
      beat_p0 <= beat;
      beat_s  <= beat_p0;
      primed  <= {primed[0], 1'b1};
    end
  end

  // Detector: a beat must be seen low before it can be accepted, then lockout
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      state    <= WAIT_LOW;
      lock_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOW: if (primed[1] && !beat_s) state <= ARMED;
        ARMED: begin
          if (beat_s) begin
            state    <= LOCK;
            lock_cnt <= LK_LOAD;
          end
        end
        LOCK: begin
          if (lock_cnt == '0) state <= WAIT_LOW;
          else                lock_cnt <= lock_cnt - LK_W'(1);
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

  assign acc     = (state == ARMED) && beat_s;
  assign wend    = (win_cnt == WIN_LAST);
  assign cur_cnt = sat_inc(beat_cnt, acc);

  // Window and beat counting; a beat on wend closes into the ending window
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      win_cnt  <= '0;
      beat_cnt <= '0;
      fl_cnt   <= '0;
    end else begin
      win_cnt  <= wend ? '0 : win_cnt + WIN_W'(1);
      beat_cnt <= wend ? 6'd0 : cur_cnt;
      if (acc)                  fl_cnt <= '0;
      else if (fl_cnt != NB_MAX) fl_cnt <= fl_cnt + NB_W'(1);
    end
  end

  assign flatline = (fl_cnt == NB_MAX);

`ifdef HART_AVG_EN
  logic [5:0] prev_cnt;

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      hart       <= 6'd0;
      hart_valid <= 1'b0;
      prev_cnt   <= 6'd0;
    end else begin
      hart_valid <= wend;
      if (wend) begin
        hart     <= round_avg(prev_cnt, cur_cnt);
        prev_cnt <= cur_cnt;
      end
    end
  end
`else
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      hart       <= 6'd0;
      hart_valid <= 1'b0;
    end else begin
      hart_valid <= wend;
      if (wend) hart <= cur_cnt;
    end
  end
`endif

endmodule
